pls_fpu_arbiter: RTL and testbench
==================================

// Module: pls_fpu_arbiter
// PURPOSE
// Shares one floating-point add/sub core between two AXI-Stream requesters in the generator core.
// Requester 0 is the configurator (subtract); requester 1 is the sample generator (add).
// Runs one operation at a time: grant, forward A/B with opcode, route result back, release.
// Sits between pls_Configurator/pls_Generator and a single FP add/sub IP with operation channel.
// PARAMETERS
// DATA_SIZE  32  operand/result width (IEEE-754 single)
// OP_SIZE    8   operation channel width (0x00 = add, 0x01 = sub)
// PORTS
// aclk               in   1          clock
// aresetn            in   1          asynchronous reset, active low
// rN_a_tdata/tvalid  in   DATA_SIZE/1  requester N (N=0,1) operand A; rN_a_tready out 1
// rN_b_tdata/tvalid  in   DATA_SIZE/1  requester N operand B; rN_b_tready out 1
// rN_res_tdata/tvalid out DATA_SIZE/1  requester N result; rN_res_tready in 1
// fpu_a_tdata/tvalid out  DATA_SIZE/1  core operand A; fpu_a_tready in 1
// fpu_b_tdata/tvalid out  DATA_SIZE/1  core operand B; fpu_b_tready in 1
// fpu_op_tdata/tvalid out OP_SIZE/1   core opcode; fpu_op_tready in 1
// fpu_res_tdata/tvalid in DATA_SIZE/1 core result; fpu_res_tready out 1
// grant              out  2          one-hot current owner, 0 when idle
// busy               out  1          operation in flight
// BEHAVIOUR
// - Reset: state IDLE; all tvalid/tready outputs 0; grant=0; busy=0; last-winner=requester 1.
// - Request N pending when rN_a_tvalid & rN_b_tvalid both high (no partial requests granted).
// - FSM IDLE -> ISSUE -> WAIT_RES -> IDLE.
// - IDLE: arbitrate registered; winner latched into grant, busy=1, go ISSUE next cycle.
// - ISSUE: fpu_a/b/op tvalid=1, data muxed from owner, op = 0x01 for r0, 0x00 for r1.
//   Each channel tracked by a done flag; tvalid drops after its own handshake; rN_a_tready =
//   fpu_a_tready & ~a_done (same for b); all three done -> WAIT_RES.
// - WAIT_RES: fpu_res_tready = owner rN_res_tready; rN_res_tvalid/tdata = core result for owner
//   only (other requester tvalid=0). On result handshake -> IDLE, grant=0, busy=0.
// - Minimum turnaround: request to fpu tvalid = 1 cycle; result handshake to next grant = 1 cycle.
// - Non-owner tready always 0; its tvalid/tdata may change freely, no effect until granted.
// - Simultaneous requests: resolved per CONFIGURATION; single request always wins.
// - Core result arriving while ISSUE not complete: fpu_res_tready=0 until WAIT_RES (no loss).
// - Stray fpu_res_tvalid in IDLE: tready=0, ignored.
// - Owner dropping tvalid mid-ISSUE is a protocol violation; arbiter keeps owner and waits.
// - aresetn low mid-operation: immediate return to reset values; in-flight result discarded.
// CONFIGURATION
// PLS_ARB_RR_EN defined: round-robin; on tie, requester opposite last winner is granted.
// PLS_ARB_RR_EN undefined: fixed priority, requester 1 (generator) always wins a tie;
//   last-winner register not built.
// TESTING
// 1. r0 A=0x40400000 B=0x3F800000 alone -> fpu_op=0x01, r0_res=0x40000000, grant 01 then 00.
// 2. r1 A=0x3F800000 B=0x3F800000 alone -> fpu_op=0x00, r1_res=0x40000000; r0_res_tvalid stays 0.
// 3. Both request 4 times back to back: RR_EN -> grants 01,10,01,10... (after reset: 01 first);
//    without -> r1 granted all 4, r0 granted after r1 drops its request.
// 4. fpu_a_tready high, fpu_b_tready held low 5 cycles -> fpu_a_tvalid 1 cycle only,
//    fpu_b_tvalid held 6 cycles, no duplicate A beat, result correct.
// 5. Owner r1_res_tready low 3 cycles with fpu_res_tvalid=1 -> fpu_res_tready=0, data held, then
//    single handshake; grant=0 next cycle.
// 6. aresetn pulsed low in WAIT_RES -> all outputs 0 same cycle; next request served normally.

Source files
------------

// File: rtl/pls_fpu_arbiter.sv
// pls_fpu_arbiter
// Shares one floating-point add/sub core between two AXI-Stream requesters.
// Requester 0 (configurator) always issues a subtract; requester 1 (sample
// generator) always issues an add. One operation is in flight at a time:
// grant, forward A/B/opcode, route the result back to the owner, release.
//
// Build option:
//   PLS_ARB_RR_EN  defined   -> round-robin tie break (opposite of last winner)
//                  undefined -> fixed priority, requester 1 wins a tie
module pls_fpu_arbiter #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned OP_SIZE   = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    // requester 0 (configurator, subtract)
    input  logic [DATA_SIZE-1:0] r0_a_tdata,
    input  logic                 r0_a_tvalid,
    output logic                 r0_a_tready,
    input  logic [DATA_SIZE-1:0] r0_b_tdata,
    input  logic                 r0_b_tvalid,
    output logic                 r0_b_tready,
    output logic [DATA_SIZE-1:0] r0_res_tdata,
    output logic                 r0_res_tvalid,
    input  logic                 r0_res_tready,
    // requester 1 (sample generator, add)
    input  logic [DATA_SIZE-1:0] r1_a_tdata,
    input  logic                 r1_a_tvalid,
    output logic                 r1_a_tready,
    input  logic [DATA_SIZE-1:0] r1_b_tdata,
    input  logic                 r1_b_tvalid,
    output logic                 r1_b_tready,
    output logic [DATA_SIZE-1:0] r1_res_tdata,
    output logic                 r1_res_tvalid,
    input  logic                 r1_res_tready,
    // shared floating-point core
    output logic [DATA_SIZE-1:0] fpu_a_tdata,
    output logic                 fpu_a_tvalid,
    input  logic                 fpu_a_tready,
    output logic [DATA_SIZE-1:0] fpu_b_tdata,
    output logic                 fpu_b_tvalid,
    input  logic                 fpu_b_tready,
    output logic [OP_SIZE-1:0]   fpu_op_tdata,
    output logic                 fpu_op_tvalid,
    input  logic                 fpu_op_tready,
    input  logic [DATA_SIZE-1:0] fpu_res_tdata,
    input  logic                 fpu_res_tvalid,
    output logic                 fpu_res_tready,
    // status
    output logic [1:0]           grant,
    output logic                 busy
);

    localparam logic [OP_SIZE-1:0] OP_ADD = '0;
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RES
    } state_e;

    state_e     state_q;
    logic [1:0] grant_q;
    logic       busy_q;
    logic       a_done_q;
    logic       b_done_q;
    logic       op_done_q;
`ifdef PLS_ARB_RR_EN
    logic       last_q;     // 1 = requester 1 won the previous arbitration
`endif

    logic       req0;
    logic       req1;
    logic       win1;
    logic       in_issue;
    logic       in_wait;
    logic       own_a_tvalid;
    logic       own_b_tvalid;
    logic       own_res_tready;
    logic       a_hs;
    logic       b_hs;
    logic       op_hs;
    logic       res_hs;
    logic       a_done_d;
    logic       b_done_d;
    logic       op_done_d;
    logic       issue_done;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_wait  = (state_q == ST_WAIT_RES);

    // A request only counts when both operands are offered together
    assign req0 = r0_a_tvalid & r0_b_tvalid;
    assign req1 = r1_a_tvalid & r1_b_tvalid;

    // Arbitration: a lone request always wins; a tie follows the build option
    always_comb begin
        win1 = req1;
`ifdef PLS_ARB_RR_EN
        if (req0 && req1) begin
            win1 = ~last_q;
        end
`endif
    end

    // Owner-side views used by the shared core channels
    always_comb begin
        own_a_tvalid   = grant_q[1] ? r1_a_tvalid   : r0_a_tvalid;
        own_b_tvalid   = grant_q[1] ? r1_b_tvalid   : r0_b_tvalid;
        own_res_tready = grant_q[1] ? r1_res_tready : r0_res_tready;
    end

    // Core operand/opcode channels; each drops valid after its own handshake
    always_comb begin
        fpu_a_tvalid  = in_issue & ~a_done_q & own_a_tvalid;
        fpu_b_tvalid  = in_issue & ~b_done_q & own_b_tvalid;
        fpu_op_tvalid = in_issue & ~op_done_q;
        fpu_a_tdata   = grant_q[1] ? r1_a_tdata : r0_a_tdata;
        fpu_b_tdata   = grant_q[1] ? r1_b_tdata : r0_b_tdata;
        fpu_op_tdata  = grant_q[0] ? OP_SUB : OP_ADD;
    end

    // Requester readies: only the owner sees the core's ready, once per beat
    always_comb begin
        r0_a_tready = grant_q[0] & in_issue & ~a_done_q & fpu_a_tready;
        r0_b_tready = grant_q[0] & in_issue & ~b_done_q & fpu_b_tready;
        r1_a_tready = grant_q[1] & in_issue & ~a_done_q & fpu_a_tready;
        r1_b_tready = grant_q[1] & in_issue & ~b_done_q & fpu_b_tready;
    end

    // Result routing: accepted only in WAIT_RES and only toward the owner
    always_comb begin
        fpu_res_tready = in_wait & own_res_tready;
        r0_res_tvalid  = in_wait & grant_q[0] & fpu_res_tvalid;
        r1_res_tvalid  = in_wait & grant_q[1] & fpu_res_tvalid;
        r0_res_tdata   = (in_wait & grant_q[0]) ? fpu_res_tdata : '0;
        r1_res_tdata   = (in_wait & grant_q[1]) ? fpu_res_tdata : '0;
    end

    // Handshake detection and per-channel completion tracking
    always_comb begin
        a_hs       = fpu_a_tvalid & fpu_a_tready;
        b_hs       = fpu_b_tvalid & fpu_b_tready;
        op_hs      = fpu_op_tvalid & fpu_op_tready;
        res_hs     = fpu_res_tvalid & fpu_res_tready;
        a_done_d   = a_done_q | a_hs;
        b_done_d   = b_done_q | b_hs;
        op_done_d  = op_done_q | op_hs;
        issue_done = a_done_d & b_done_d & op_done_d;
    end

    assign grant = grant_q;
    assign busy  = busy_q;

    // Operation sequencer: IDLE -> ISSUE -> WAIT_RES -> IDLE
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            op_done_q <= 1'b0;
`ifdef PLS_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant_q   <= win1 ? 2'b10 : 2'b01;
                        busy_q    <= 1'b1;
                        a_done_q  <= 1'b0;
                        b_done_q  <= 1'b0;
                        op_done_q <= 1'b0;
`ifdef PLS_ARB_RR_EN
                        last_q    <= win1;
`endif
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    a_done_q  <= a_done_d;
                    b_done_q  <= b_done_d;
                    op_done_q <= op_done_d;
                    if (issue_done) begin
                        state_q <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_hs) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pls_fpu_arbiter.sv
// Bench for pls_fpu_arbiter: directed requests, a behavioural FP core with a
// hand-built result table, and a monitor that checks grants, opcodes and
// results against queues filled by the stimulus.
module tb_pls_fpu_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [31:0] r0_a_tdata, r0_b_tdata, r0_res_tdata;
    logic        r0_a_tvalid, r0_a_tready, r0_b_tvalid, r0_b_tready;
    logic        r0_res_tvalid, r0_res_tready;
    logic [31:0] r1_a_tdata, r1_b_tdata, r1_res_tdata;
    logic        r1_a_tvalid, r1_a_tready, r1_b_tvalid, r1_b_tready;
    logic        r1_res_tvalid, r1_res_tready;
    logic [31:0] fpu_a_tdata, fpu_b_tdata, fpu_res_tdata;
    logic [7:0]  fpu_op_tdata;
    logic        fpu_a_tvalid, fpu_a_tready, fpu_b_tvalid, fpu_b_tready;
    logic        fpu_op_tvalid, fpu_op_tready, fpu_res_tvalid, fpu_res_tready;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_res0[$];
    logic [31:0] exp_res1[$];
    logic [1:0]  exp_grant[$];

    int a_vcyc, b_vcyc, a_hs_cnt, r0_vcyc, r1_hs_cnt;
    logic [1:0] prev_grant;

    pls_fpu_arbiter #(.DATA_SIZE(32), .OP_SIZE(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .r0_a_tdata(r0_a_tdata), .r0_a_tvalid(r0_a_tvalid), .r0_a_tready(r0_a_tready),
        .r0_b_tdata(r0_b_tdata), .r0_b_tvalid(r0_b_tvalid), .r0_b_tready(r0_b_tready),
        .r0_res_tdata(r0_res_tdata), .r0_res_tvalid(r0_res_tvalid), .r0_res_tready(r0_res_tready),
        .r1_a_tdata(r1_a_tdata), .r1_a_tvalid(r1_a_tvalid), .r1_a_tready(r1_a_tready),
        .r1_b_tdata(r1_b_tdata), .r1_b_tvalid(r1_b_tvalid), .r1_b_tready(r1_b_tready),
        .r1_res_tdata(r1_res_tdata), .r1_res_tvalid(r1_res_tvalid), .r1_res_tready(r1_res_tready),
        .fpu_a_tdata(fpu_a_tdata), .fpu_a_tvalid(fpu_a_tvalid), .fpu_a_tready(fpu_a_tready),
        .fpu_b_tdata(fpu_b_tdata), .fpu_b_tvalid(fpu_b_tvalid), .fpu_b_tready(fpu_b_tready),
        .fpu_op_tdata(fpu_op_tdata), .fpu_op_tvalid(fpu_op_tvalid), .fpu_op_tready(fpu_op_tready),
        .fpu_res_tdata(fpu_res_tdata), .fpu_res_tvalid(fpu_res_tvalid), .fpu_res_tready(fpu_res_tready),
        .grant(grant), .busy(busy)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Hand-computed IEEE-754 single results for the vectors used below
    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
        if (op == 8'h01 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000; // 3-1
        if (op == 8'h00 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000; // 1+1
        if (op == 8'h01 && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000; // 5-1
        if (op == 8'h00 && a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000; // 2+3
        if (op == 8'h01 && a == 32'h41200000 && b == 32'h40000000) return 32'h41000000; // 10-2
        return 32'hDEADBEEF;
    endfunction

    // Behavioural FP core: collect A, B, op; present result after a short latency
    logic        got_a, got_b, got_op;
    logic [31:0] ma, mb, sa, sb;
    logic [7:0]  mop, sop;
    logic        s_ahs, s_bhs, s_ophs, s_rhs;
    int          lat;
    initial begin
        fpu_res_tvalid = 1'b0;
        fpu_res_tdata  = '0;
        got_a = 1'b0; got_b = 1'b0; got_op = 1'b0; lat = 0;
        ma = '0; mb = '0; mop = '0;
        forever begin
            @(negedge aclk);
            s_ahs  = fpu_a_tvalid & fpu_a_tready;   sa  = fpu_a_tdata;
            s_bhs  = fpu_b_tvalid & fpu_b_tready;   sb  = fpu_b_tdata;
            s_ophs = fpu_op_tvalid & fpu_op_tready; sop = fpu_op_tdata;
            s_rhs  = fpu_res_tvalid & fpu_res_tready;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                got_a = 1'b0; got_b = 1'b0; got_op = 1'b0; lat = 0;
                fpu_res_tvalid = 1'b0;
            end else begin
                if (s_ahs)  begin got_a  = 1'b1; ma  = sa;  end
                if (s_bhs)  begin got_b  = 1'b1; mb  = sb;  end
                if (s_ophs) begin got_op = 1'b1; mop = sop; end
                if (s_rhs) fpu_res_tvalid = 1'b0;
                if (got_a && got_b && got_op) begin
                    if (lat == 2) begin
                        fpu_res_tvalid = 1'b1;
                        fpu_res_tdata  = fpu_ref(ma, mb, mop);
                        got_a = 1'b0; got_b = 1'b0; got_op = 1'b0; lat = 0;
                    end else begin
                        lat++;
                    end
                end
            end
        end
    end

    // Monitor: grant order, opcode per owner, results per requester
    initial begin
        prev_grant = '0;
        a_vcyc = 0; b_vcyc = 0; a_hs_cnt = 0; r0_vcyc = 0; r1_hs_cnt = 0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (fpu_a_tvalid) a_vcyc++;
                if (fpu_b_tvalid) b_vcyc++;
                if (fpu_a_tvalid && fpu_a_tready) a_hs_cnt++;
                if (r0_res_tvalid) r0_vcyc++;
                if (fpu_op_tvalid && fpu_op_tready)
                    check("fpu_op", {24'h0, fpu_op_tdata},
                          grant == 2'b01 ? 32'h1 : (grant == 2'b10 ? 32'h0 : 32'hFF));
                if (grant != 2'b00 && prev_grant == 2'b00) begin
                    check("busy_on_grant", {31'h0, busy}, 32'h1);
                    if (exp_grant.size() == 0) fail_now("grant_unexpected");
                    else check("grant", {30'h0, grant}, {30'h0, exp_grant.pop_front()});
                end
                if (r0_res_tvalid && r0_res_tready) begin
                    if (exp_res0.size() == 0) fail_now("r0_res_unexpected");
                    else check("r0_res", r0_res_tdata, exp_res0.pop_front());
                end
                if (r1_res_tvalid && r1_res_tready) begin
                    r1_hs_cnt++;
                    if (exp_res1.size() == 0) fail_now("r1_res_unexpected");
                    else check("r1_res", r1_res_tdata, exp_res1.pop_front());
                end
            end
            prev_grant = grant;
        end
    end

    // Offer one A/B pair on requester n and hold each until accepted
    task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        bit ad = 0;
        bit bd = 0;
        bit ahs, bhs;
        int cyc = 0;
        if (n == 0) begin
            exp_res0.push_back(exp);
            r0_a_tdata = a; r0_b_tdata = b; r0_a_tvalid = 1'b1; r0_b_tvalid = 1'b1;
        end else begin
            exp_res1.push_back(exp);
            r1_a_tdata = a; r1_b_tdata = b; r1_a_tvalid = 1'b1; r1_b_tvalid = 1'b1;
        end
        while (!(ad && bd)) begin
            @(negedge aclk);
            ahs = (n == 0) ? (r0_a_tvalid & r0_a_tready) : (r1_a_tvalid & r1_a_tready);
            bhs = (n == 0) ? (r0_b_tvalid & r0_b_tready) : (r1_b_tvalid & r1_b_tready);
            @(posedge aclk);
            #1;
            if (ahs) begin
                ad = 1;
                if (n == 0) r0_a_tvalid = 1'b0; else r1_a_tvalid = 1'b0;
            end
            if (bhs) begin
                bd = 1;
                if (n == 0) r0_b_tvalid = 1'b0; else r1_b_tvalid = 1'b0;
            end
            cyc++;
            if (cyc > 300 && !(ad && bd)) begin
                fail_now("send_timeout");
                if (n == 0) begin r0_a_tvalid = 1'b0; r0_b_tvalid = 1'b0; end
                else begin r1_a_tvalid = 1'b0; r1_b_tvalid = 1'b0; end
                ad = 1; bd = 1;
            end
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0: return fpu_b_tvalid;
            1: return fpu_res_tvalid;
            default: return r0_res_tvalid;
        endcase
    endfunction

    // Advance to the first falling edge where the chosen signal is high
    task automatic wait_for(input int w, input string name);
        int c = 0;
        @(negedge aclk);
        while (!sel(w) && c < 100) begin
            @(negedge aclk);
            c++;
        end
        if (!sel(w)) fail_now(name);
    endtask

    // Wait until every expected result has been returned and the arbiter is idle
    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_res0.size() != 0 || exp_res1.size() != 0 || grant != 2'b00) && c < 400) begin
            @(negedge aclk);
            c++;
        end
        if (c >= 400) fail_now(name);
        check({name, "_grant_left"}, exp_grant.size(), 0);
        check({name, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        r0_a_tdata = '0; r0_b_tdata = '0; r0_a_tvalid = 1'b0; r0_b_tvalid = 1'b0;
        r1_a_tdata = '0; r1_b_tdata = '0; r1_a_tvalid = 1'b0; r1_b_tvalid = 1'b0;
        r0_res_tready = 1'b1; r1_res_tready = 1'b1;
        fpu_a_tready = 1'b1; fpu_b_tready = 1'b1; fpu_op_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_fpu_valids", {29'h0, fpu_a_tvalid, fpu_b_tvalid, fpu_op_tvalid}, 32'h0);
        check("rst_fpu_res_tready", {31'h0, fpu_res_tready}, 32'h0);
        check("rst_req_readies", {28'h0, r0_a_tready, r0_b_tready, r1_a_tready, r1_b_tready}, 32'h0);
        check("rst_res_valids", {30'h0, r0_res_tvalid, r1_res_tvalid}, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: requester 0 alone, 3 - 1
        exp_grant.push_back(2'b01);
        send(0, 32'h40400000, 32'h3F800000, 32'h40000000);
        wait_drain("t1");

        // 2: requester 1 alone, 1 + 1; requester 0 never sees a result
        r0_vcyc = 0;
        exp_grant.push_back(2'b10);
        send(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        wait_drain("t2");
        check("t2_r0_res_tvalid_cycles", r0_vcyc, 0);

        // 3: both requesters back to back, four operations each
`ifdef PLS_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back(2'b01);
            exp_grant.push_back(2'b10);
        end
`else
        for (int i = 0; i < 4; i++) exp_grant.push_back(2'b10);
        for (int i = 0; i < 4; i++) exp_grant.push_back(2'b01);
`endif
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 32'h40A00000, 32'h3F800000, 32'h40800000);
            end
            begin
                for (int j = 0; j < 4; j++) send(1, 32'h40000000, 32'h40400000, 32'h40A00000);
            end
        join
        wait_drain("t3");

        // 4: core holds B ready low for five cycles, 10 - 2
        a_vcyc = 0; b_vcyc = 0; a_hs_cnt = 0;
        fpu_b_tready = 1'b0;
        exp_grant.push_back(2'b01);
        fork
            send(0, 32'h41200000, 32'h40000000, 32'h41000000);
            begin
                wait_for(0, "t4_b_valid_timeout");
                repeat (5) @(posedge aclk);
                #1;
                fpu_b_tready = 1'b1;
            end
        join
        wait_drain("t4");
        check("t4_a_valid_cycles", a_vcyc, 1);
        check("t4_b_valid_cycles", b_vcyc, 6);
        check("t4_a_handshakes", a_hs_cnt, 1);

        // 5: owner back-pressures the result for three cycles
        r1_hs_cnt = 0;
        r1_res_tready = 1'b0;
        exp_grant.push_back(2'b10);
        send(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        wait_for(1, "t5_res_valid_timeout");
        for (int k = 0; k < 3; k++) begin
            check("t5_fpu_res_tready_low", {31'h0, fpu_res_tready}, 32'h0);
            check("t5_r1_res_tvalid", {31'h0, r1_res_tvalid}, 32'h1);
            check("t5_r1_res_held", r1_res_tdata, 32'h40000000);
            if (k < 2) @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        r1_res_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("t5_grant_released", {30'h0, grant}, 32'h0);
        check("t5_single_handshake", r1_hs_cnt, 1);
        wait_drain("t5");

        // 6: reset pulse while waiting for the result, then a normal operation
        r0_res_tready = 1'b0;
        exp_grant.push_back(2'b01);
        send(0, 32'h40400000, 32'h3F800000, 32'h40000000);
        wait_for(2, "t6_res_valid_timeout");
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_grant_busy", {29'h0, grant, busy}, 32'h0);
        check("t6_fpu_valids", {29'h0, fpu_a_tvalid, fpu_b_tvalid, fpu_op_tvalid}, 32'h0);
        check("t6_readies", {27'h0, fpu_res_tready, r0_a_tready, r0_b_tready, r1_a_tready, r1_b_tready}, 32'h0);
        check("t6_res_valids", {30'h0, r0_res_tvalid, r1_res_tvalid}, 32'h0);
        exp_res0.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        r0_res_tready = 1'b1;
        @(posedge aclk);
        #1;
        exp_grant.push_back(2'b01);
        send(0, 32'h40400000, 32'h3F800000, 32'h40000000);
        wait_drain("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
